// File: rtl/branch_pkg.sv
// Shared definitions for the branch evaluation path: opcode bytes, the
// architectural flag bundle and the Jcc condition-code evaluator.
package branch_pkg;

  localparam logic [7:0] OP_JO     = 8'h70;
  localparam logic [7:0] OP_JNO    = 8'h71;
  localparam logic [7:0] OP_JB     = 8'h72;
  localparam logic [7:0] OP_JAE    = 8'h73;
  localparam logic [7:0] OP_JE     = 8'h74;
  localparam logic [7:0] OP_JNE    = 8'h75;
  localparam logic [7:0] OP_JBE    = 8'h76;
  localparam logic [7:0] OP_JA     = 8'h77;
  localparam logic [7:0] OP_JS     = 8'h78;
  localparam logic [7:0] OP_JNS    = 8'h79;
  localparam logic [7:0] OP_JP     = 8'h7A;
  localparam logic [7:0] OP_JNP    = 8'h7B;
  localparam logic [7:0] OP_JL     = 8'h7C;
  localparam logic [7:0] OP_JNL    = 8'h7D;
  localparam logic [7:0] OP_JLE    = 8'h7E;
  localparam logic [7:0] OP_JNLE   = 8'h7F;
  localparam logic [7:0] OP_JMPS   = 8'hEB;
  localparam logic [7:0] OP_JMPN   = 8'hE9;
  localparam logic [7:0] OP_LOOPNZ = 8'hE0;
  localparam logic [7:0] OP_LOOPZ  = 8'hE1;
  localparam logic [7:0] OP_LOOP   = 8'hE2;
  localparam logic [7:0] OP_JCXZ   = 8'hE3;
  localparam logic [7:0] ESC_0F    = 8'h0F;

  typedef struct packed {
    logic vf;
    logic sf;
    logic zf;
    logic pf;
    logic cf;
  } flags_t;

  // Even codes test the condition, odd codes its inverse.
  function automatic logic cond_eval(input logic [3:0] cc, input flags_t f);
    logic r;
    case (cc[3:1])
      3'd0:    r = f.vf;
      3'd1:    r = f.cf;
      3'd2:    r = f.zf;
      3'd3:    r = f.cf | f.zf;
      3'd4:    r = f.sf;
      3'd5:    r = f.pf;
      3'd6:    r = f.sf ^ f.vf;
      3'd7:    r = (f.sf ^ f.vf) | f.zf;
      default: r = 1'b0;
    endcase
    return r ^ cc[0];
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch decode: classifies the opcode and resolves taken
// from flags and the (already size-masked) effective count.
module branch_cond
  import branch_pkg::*;
#(
  parameter int AW       = 32,
  parameter int NEAR_JCC = 1
) (
  input  logic          i_prefix0f,
  input  logic [7:0]    i_op,
  input  flags_t        i_flags,
  input  logic [AW-1:0] i_ec,
  output logic          o_taken,
  output logic          o_is_loop,
  output logic          o_bad_op
);

  logic w_ec_zero;
  logic w_dec_nz;

  assign w_ec_zero = (i_ec == {AW{1'b0}});
  // ec-1 is zero only when ec is one; ec==0 wraps to all-ones.
  assign w_dec_nz  = (i_ec != AW'(32'd1));

  // Opcode classification and taken resolution.
  always_comb begin
    o_taken   = 1'b0;
    o_is_loop = 1'b0;
    o_bad_op  = 1'b0;
    if (i_prefix0f) begin
      if ((NEAR_JCC != 0) && (i_op[7:4] == 4'h8)) begin
        o_taken = cond_eval(i_op[3:0], i_flags);
      end else begin
        o_bad_op = 1'b1;
      end
    end else if (i_op[7:4] == 4'h7) begin
      o_taken = cond_eval(i_op[3:0], i_flags);
    end else begin
      case (i_op)
        OP_JMPS, OP_JMPN: o_taken = 1'b1;
        OP_LOOP: begin
          o_is_loop = 1'b1;
          o_taken   = w_dec_nz;
        end
        OP_LOOPZ: begin
          o_is_loop = 1'b1;
          o_taken   = w_dec_nz & i_flags.zf;
        end
        OP_LOOPNZ: begin
          o_is_loop = 1'b1;
          o_taken   = w_dec_nz & ~i_flags.zf;
        end
        OP_JCXZ: o_taken = w_ec_zero;
        default: o_bad_op = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_eval_unit.sv
// Registered branch evaluator: decode, LOOP count decrement and target add,
// presented through a one-entry valid/ready output register.
module branch_eval_unit
  import branch_pkg::*;
#(
  parameter int AW         = 32,
  parameter int NEAR_JCC   = 1,
  parameter int FLUSH_HOLD = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic          prefix0f_i,
  input  logic [7:0]    op_i,
  input  logic          big_i,
  input  logic [4:0]    flags_i,
  input  logic [AW-1:0] count_i,
  input  logic [AW-1:0] next_ip_i,
  input  logic [AW-1:0] disp_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          taken_o,
  output logic [AW-1:0] target_o,
  output logic          count_we_o,
  output logic [AW-1:0] count_o,
  output logic          bad_op_o
);

  logic          r_valid;
  logic          r_taken;
  logic [AW-1:0] r_target;
  logic          r_count_we;
  logic [AW-1:0] r_count;
  logic          r_bad_op;

  logic          w_big;
  logic          w_accept;
  logic [AW-1:0] w_mask16;
  logic [AW-1:0] w_ec;
  logic [AW-1:0] w_dec;
  logic [AW-1:0] w_count;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_target;
  logic          w_taken;
  logic          w_is_loop;
  logic          w_bad_op;

  assign w_big      = (AW > 16) ? big_i : 1'b0;
  assign in_ready_o = ~r_valid | out_ready_i;
  assign w_accept   = in_valid_i & in_ready_o & ~flush_i;

  assign w_mask16 = AW'(32'h0000_FFFF);
  assign w_ec     = w_big ? count_i : (count_i & w_mask16);
  assign w_dec    = w_ec - AW'(32'd1);
  // In 16-bit mode only CX changes; the upper count bits pass through.
  assign w_count  = w_big ? w_dec : ((count_i & ~w_mask16) | (w_dec & w_mask16));
  assign w_sum    = next_ip_i + disp_i;
  assign w_target = w_big ? w_sum : (w_sum & w_mask16);

  branch_cond #(
    .AW       (AW),
    .NEAR_JCC (NEAR_JCC)
  ) u_cond (
    .i_prefix0f (prefix0f_i),
    .i_op       (op_i),
    .i_flags    (flags_t'(flags_i)),
    .i_ec       (w_ec),
    .o_taken    (w_taken),
    .o_is_loop  (w_is_loop),
    .o_bad_op   (w_bad_op)
  );

  // Result fields load on acceptance and otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_taken    <= 1'b0;
      r_target   <= {AW{1'b0}};
      r_count_we <= 1'b0;
      r_count    <= {AW{1'b0}};
      r_bad_op   <= 1'b0;
    end else if (w_accept) begin
      r_taken    <= w_taken;
      r_target   <= w_target;
      r_count_we <= w_is_loop;
      r_count    <= w_count;
      r_bad_op   <= w_bad_op;
    end else begin
      r_taken    <= r_taken;
      r_target   <= r_target;
      r_count_we <= r_count_we;
      r_count    <= r_count;
      r_bad_op   <= r_bad_op;
    end
  end

  // Valid is set by accept and cleared by drain or an optional flush drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (out_ready_i || ((FLUSH_HOLD != 0) && flush_i)) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign out_valid_o = r_valid;
  assign taken_o     = r_taken;
  assign target_o    = r_target;
  assign count_we_o  = r_count_we;
  assign count_o     = r_count;
  assign bad_op_o    = r_bad_op;

endmodule

// File: tb/tb_branch_eval_unit.sv
// Directed self-checking bench for branch_eval_unit: default build plus
// NEAR_JCC=0 and FLUSH_HOLD=1 variants driven from the same stimulus.
module tb_branch_eval_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        prefix0f;
  logic [7:0]  op;
  logic        big;
  logic [4:0]  flags;
  logic [31:0] count;
  logic [31:0] next_ip;
  logic [31:0] disp;
  logic        out_ready;

  logic        m_in_ready, m_valid, m_taken, m_cwe, m_bad;
  logic [31:0] m_target, m_count;
  logic        nj_in_ready, nj_valid, nj_taken, nj_cwe, nj_bad;
  logic [31:0] nj_target, nj_count;
  logic        fh_in_ready, fh_valid, fh_taken, fh_cwe, fh_bad;
  logic [31:0] fh_target, fh_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] got_q[$];

  branch_eval_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(m_in_ready), .prefix0f_i(prefix0f), .op_i(op), .big_i(big),
    .flags_i(flags), .count_i(count), .next_ip_i(next_ip), .disp_i(disp),
    .out_valid_o(m_valid), .out_ready_i(out_ready), .taken_o(m_taken),
    .target_o(m_target), .count_we_o(m_cwe), .count_o(m_count), .bad_op_o(m_bad)
  );

  branch_eval_unit #(.NEAR_JCC(0)) dut_nj (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(nj_in_ready), .prefix0f_i(prefix0f), .op_i(op), .big_i(big),
    .flags_i(flags), .count_i(count), .next_ip_i(next_ip), .disp_i(disp),
    .out_valid_o(nj_valid), .out_ready_i(out_ready), .taken_o(nj_taken),
    .target_o(nj_target), .count_we_o(nj_cwe), .count_o(nj_count), .bad_op_o(nj_bad)
  );

  branch_eval_unit #(.FLUSH_HOLD(1)) dut_fh (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(fh_in_ready), .prefix0f_i(prefix0f), .op_i(op), .big_i(big),
    .flags_i(flags), .count_i(count), .next_ip_i(next_ip), .disp_i(disp),
    .out_valid_o(fh_valid), .out_ready_i(out_ready), .taken_o(fh_taken),
    .target_o(fh_target), .count_we_o(fh_cwe), .count_o(fh_count), .bad_op_o(fh_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every target handed over on the default instance.
  always @(posedge clk) begin
    if (m_valid && out_ready) got_q.push_back(m_target);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [7:0] o, input logic b,
                       input logic [4:0] f, input logic [31:0] c,
                       input logic [31:0] nip, input logic [31:0] d);
    prefix0f = p; op = o; big = b; flags = f;
    count = c; next_ip = nip; disp = d; in_valid = 1'b1;
  endtask

  task automatic issue(input logic p, input logic [7:0] o, input logic b,
                       input logic [4:0] f, input logic [31:0] c,
                       input logic [31:0] nip, input logic [31:0] d);
    drive(p, o, b, f, c, nip, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    prefix0f = 1'b0; op = 8'h00; big = 1'b1; flags = 5'b00000;
    count = 32'h0; next_ip = 32'h0; disp = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid",  {31'd0, m_valid}, 32'd0);
    chk("rst_target", m_target, 32'h0);
    chk("rst_count",  m_count, 32'h0);
    chk("rst_flags",  {29'd0, m_taken, m_cwe, m_bad}, 32'd0);
    rst_n = 1'b1;

    issue(1'b0, 8'hE2, 1'b1, 5'b00000, 32'h1, 32'h1000, 32'hFFFF_FFF0);
    chk("loop32_valid",  {31'd0, m_valid}, 32'd1);
    chk("loop32_taken",  {31'd0, m_taken}, 32'd0);
    chk("loop32_cwe",    {31'd0, m_cwe},   32'd1);
    chk("loop32_count",  m_count,  32'h0);
    chk("loop32_target", m_target, 32'h0000_0FF0);

    issue(1'b0, 8'hE2, 1'b0, 5'b00000, 32'h1234_0000, 32'h0000_FFFE, 32'h4);
    chk("loop16_count",  m_count,  32'h1234_FFFF);
    chk("loop16_taken",  {31'd0, m_taken}, 32'd1);
    chk("loop16_target", m_target, 32'h0000_0002);

    issue(1'b0, 8'h7E, 1'b1, 5'b01000, 32'h0, 32'h0, 32'h0);
    chk("jle_taken",    {31'd0, m_taken},  32'd1);
    chk("jle_nj_taken", {31'd0, nj_taken}, 32'd1);
    issue(1'b0, 8'h7F, 1'b1, 5'b01000, 32'h0, 32'h0, 32'h0);
    chk("jnle_taken", {31'd0, m_taken}, 32'd0);
    issue(1'b1, 8'h8E, 1'b1, 5'b01000, 32'h0, 32'h0, 32'h0);
    chk("near_taken",    {31'd0, m_taken},  32'd1);
    chk("near_bad",      {31'd0, m_bad},    32'd0);
    chk("near_nj_bad",   {31'd0, nj_bad},   32'd1);
    chk("near_nj_taken", {31'd0, nj_taken}, 32'd0);
    chk("near_nj_valid", {31'd0, nj_valid}, 32'd1);

    issue(1'b0, 8'hE1, 1'b1, 5'b00000, 32'h5, 32'h0, 32'h0);
    chk("loopz_taken", {31'd0, m_taken}, 32'd0);
    chk("loopz_count", m_count, 32'h4);
    issue(1'b0, 8'hE3, 1'b1, 5'b00000, 32'h0, 32'h0, 32'h0);
    chk("jecxz_taken", {31'd0, m_taken}, 32'd1);
    chk("jecxz_cwe",   {31'd0, m_cwe},   32'd0);
    issue(1'b0, 8'hE3, 1'b0, 5'b00000, 32'h0001_0000, 32'h0, 32'h0);
    chk("jcxz16_taken", {31'd0, m_taken}, 32'd1);
    issue(1'b0, 8'hC3, 1'b1, 5'b00000, 32'h0, 32'h0, 32'h0);
    chk("bad_bad",   {31'd0, m_bad},   32'd1);
    chk("bad_taken", {31'd0, m_taken}, 32'd0);
    chk("bad_cwe",   {31'd0, m_cwe},   32'd0);
    chk("bad_valid", {31'd0, m_valid}, 32'd1);
    @(posedge clk); #1;
    chk("drain_valid", {31'd0, m_valid}, 32'd0);

    // Back-to-back with a two-cycle consumer stall.
    got_q.delete();
    out_ready = 1'b0;
    issue(1'b0, 8'hEB, 1'b1, 5'b00000, 32'h0, 32'h100, 32'h0);
    drive(1'b0, 8'hEB, 1'b1, 5'b00000, 32'h0, 32'h200, 32'h0);
    chk("stall_in_ready", {31'd0, m_in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("stall_hold1", m_target, 32'h100);
    @(posedge clk); #1;
    chk("stall_hold2", m_target, 32'h100);
    chk("stall_valid", {31'd0, m_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("resume_in_ready", {31'd0, m_in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_second", m_target, 32'h200);
    drive(1'b0, 8'hEB, 1'b1, 5'b00000, 32'h0, 32'h300, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_third", m_target, 32'h300);
    @(posedge clk); #1;
    chk("b2b_empty", {31'd0, m_valid}, 32'd0);
    chk("b2b_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      chk("b2b_order0", got_q[0], 32'h100);
      chk("b2b_order1", got_q[1], 32'h200);
      chk("b2b_order2", got_q[2], 32'h300);
    end

    // Flush while idle blocks acceptance.
    drive(1'b0, 8'hEB, 1'b1, 5'b00000, 32'h0, 32'h700, 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_valid", {31'd0, m_valid}, 32'd0);

    // Flush with a pending result: dropped only in the FLUSH_HOLD build.
    out_ready = 1'b0;
    issue(1'b0, 8'hEB, 1'b1, 5'b00000, 32'h0, 32'h400, 32'h0);
    drive(1'b0, 8'hEB, 1'b1, 5'b00000, 32'h0, 32'h500, 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_fh_valid", {31'd0, fh_valid}, 32'd0);
    chk("flush_m_valid",  {31'd0, m_valid},  32'd1);
    chk("flush_m_target", m_target, 32'h400);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("flush_drain", {31'd0, m_valid}, 32'd0);

    // Asynchronous reset mid-cycle while a result is pending.
    out_ready = 1'b0;
    issue(1'b0, 8'hE2, 1'b1, 5'b00000, 32'h9, 32'h600, 32'h0);
    chk("pre_rst_valid", {31'd0, m_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",  {31'd0, m_valid}, 32'd0);
    chk("arst_target", m_target, 32'h0);
    chk("arst_count",  m_count, 32'h0);
    chk("arst_cwe",    {31'd0, m_cwe}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
